// File: rtl/fir_pkg.sv
// Shared defaults and FSM state encoding for the sequential FIR tap engine.
package fir_pkg;

  localparam int FIR_NTAPS  = 64;
  localparam int FIR_DW     = 16;
  localparam int FIR_ACCW   = 40;
  localparam int FIR_QSHIFT = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } fir_state_t;

endpackage

// File: rtl/fir_delay_line.sv
// NTAPS x DW circular sample buffer: one synchronous write port, one combinational read port.
// Asynchronous clear of every entry so a reset leaves no stale history behind.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS,
  parameter int DW    = FIR_DW,
  localparam int AW   = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [NTAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fir_tap_seq.sv
// Sequential FIR, one MAC per cycle against an external coefficient ROM; FIR_TAP_SEQ_SAT_EN saturates the output.
// Latency: handshake in cycle 0, out_valid in cycle NTAPS+2.
// Backpressure: in_ready only in IDLE; OUT holds out_valid/out_sample until out_ready.
module fir_tap_seq
  import fir_pkg::*;
#(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int DW     = FIR_DW,
  parameter int ACCW   = FIR_ACCW,
  parameter int QSHIFT = FIR_QSHIFT,
  localparam int AW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sample,
  input  logic          rising_tone,
  output logic [AW-1:0] coef_addr,
  output logic          coef_bank,
  input  logic [DW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sample,
  output logic          busy
);

  fir_state_t              r_state;
  logic [AW-1:0]           r_k;
  logic [AW-1:0]           r_wr_ptr;
  logic signed [ACCW-1:0]  r_acc;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [DW-1:0]           r_out_sample;
  logic                    r_coef_bank;
  logic                    r_busy;

  logic                    w_wr_en;
  logic [AW-1:0]           w_rd_idx;
  logic [DW-1:0]           w_rd_data;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACCW-1:0]  w_prod_ext;
  logic [DW-1:0]           w_rounded;

  assign w_wr_en = (r_state == S_IDLE) && r_in_ready && in_valid;

  // Newest sample sits at wr_ptr, so tap k reads k entries back, wrapping around the buffer.
  always_comb begin
    if (r_wr_ptr >= r_k) w_rd_idx = r_wr_ptr - r_k;
    else                 w_rd_idx = AW'(NTAPS) + r_wr_ptr - r_k;
  end

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_sample),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  assign w_prod     = $signed(coef_data) * $signed(w_rd_data);
  assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};

`ifdef FIR_TAP_SEQ_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACCW-1:0] w_shifted;

  assign w_shifted = r_acc >>> QSHIFT;

  always_comb begin
    if (w_shifted > SAT_MAX)      w_rounded = SAT_MAX[DW-1:0];
    else if (w_shifted < SAT_MIN) w_rounded = SAT_MIN[DW-1:0];
    else                          w_rounded = w_shifted[DW-1:0];
  end
`else
  // Low DW bits of an arithmetic shift are just a slice of the accumulator.
  assign w_rounded = r_acc[QSHIFT +: DW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_wr_ptr     <= '0;
      r_acc        <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_coef_bank  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_in_ready && in_valid) begin
            r_acc       <= '0;
            r_k         <= '0;
            r_coef_bank <= rising_tone;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_MAC;
          end else begin
            r_in_ready  <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_k == AW'(NTAPS - 1)) begin
            r_k     <= '0;
            r_state <= S_ROUND;
          end else begin
            r_k     <= r_k + AW'(1);
          end
        end
        S_ROUND: begin
          r_out_sample <= w_rounded;
          r_wr_ptr     <= (r_wr_ptr == AW'(NTAPS - 1)) ? '0 : r_wr_ptr + AW'(1);
          r_out_valid  <= 1'b1;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign coef_addr  = r_k;
  assign coef_bank  = r_coef_bank;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign busy       = r_busy;

endmodule

// File: tb/tb_fir_tap_seq.sv
// Directed bench for fir_tap_seq with a combinational two-bank coefficient ROM and a sample-history model.
module tb_fir_tap_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sample;
  logic        rising_tone;
  logic [5:0]  coef_addr;
  logic        coef_bank;
  logic [15:0] coef_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] xm [64];
  int                 mwp;

  always #5 clk = ~clk;

  fir_tap_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .rising_tone (rising_tone),
    .coef_addr   (coef_addr),
    .coef_bank   (coef_bank),
    .coef_data   (coef_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sample  (out_sample),
    .busy        (busy)
  );

  function automatic logic signed [15:0] h0(input int k);
    if (k == 0) return 16'sd16384;
    return 16'(((k * 1237) % 8192) - 4096);
  endfunction

  function automatic logic signed [15:0] h1(input int k);
    return 16'(20000 - 300 * k);
  endfunction

  always_comb coef_data = coef_bank ? h1(int'(coef_addr)) : h0(int'(coef_addr));

  task automatic model_reset();
    for (int i = 0; i < 64; i++) xm[i] = '0;
    mwp = 0;
  endtask

  task automatic model_push(input logic signed [15:0] s, input logic bank, output logic [15:0] e);
    longint acc;
    int     idx;
    acc = 0;
    xm[mwp] = s;
    for (int k = 0; k < 64; k++) begin
      idx = (mwp - k + 64) % 64;
      acc += longint'(bank ? h1(k) : h0(k)) * longint'(xm[idx]);
    end
    acc = acc >>> 15;
`ifdef FIR_TAP_SEQ_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    e = acc[15:0];
    mwp = (mwp + 1) % 64;
  endtask

  // Drives one sample; lat is the cycle out_valid appeared (-1 timeout, -2 reset injected at abort_k).
  task automatic run_sample(input logic [15:0] s, input logic bank, input bit hold,
                            input int flip_k, input int abort_k,
                            output logic [15:0] got, output logic bank_seen, output int lat);
    got = '0;
    bank_seen = 1'b0;
    lat = -1;
    @(negedge clk);
    for (int w = 0; w < 20 && in_ready !== 1'b1; w++) @(negedge clk);
    if (in_ready !== 1'b1) return;
    in_valid    = 1'b1;
    in_sample   = s;
    rising_tone = bank;
    out_ready   = !hold;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sample = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (flip_k >= 0 && busy && int'(coef_addr) == flip_k) rising_tone = ~rising_tone;
      if (abort_k >= 0 && busy && int'(coef_addr) == abort_k) begin
        rst_n = 1'b0;
        lat = -2;
        return;
      end
      if (out_valid === 1'b1) begin
        got = out_sample;
        bank_seen = coef_bank;
        lat = c;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_sample = '0; rising_tone = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (coef_addr !== 6'd0) begin n_fail++; $display("FAIL reset_coef_addr: got %0d expected 0", coef_addr); end
    n_tests++; if (coef_bank !== 1'b0) begin n_fail++; $display("FAIL reset_coef_bank: got %b expected 0", coef_bank); end
    n_tests++; if (out_sample !== 16'd0) begin n_fail++; $display("FAIL reset_out_sample: got %0d expected 0", out_sample); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_pre_edge: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready_post_edge: got %b expected 1", in_ready); end
    model_reset();
  endtask

  task automatic test_zero_latency();
    logic [15:0] got, e;
    logic        bs;
    int          lat;
    run_sample(16'd0, 1'b0, 1'b0, -1, -1, got, bs, lat);
    model_push(16'sd0, 1'b0, e);
    n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL zero_latency: got %0d expected 66", lat); end
    n_tests++; if (got !== 16'd0) begin n_fail++; $display("FAIL zero_output: got %0d expected 0", $signed(got)); end
  endtask

  task automatic test_impulse();
    logic [15:0] got, e;
    logic        bs;
    int          lat;
    for (int n = 0; n < 64; n++) begin
      run_sample((n == 0) ? 16'd32767 : 16'd0, 1'b0, 1'b0, -1, -1, got, bs, lat);
      model_push((n == 0) ? 16'sd32767 : 16'sd0, 1'b0, e);
      n_tests++; if (got !== e) begin n_fail++; $display("FAIL impulse_out[%0d]: got %0d expected %0d", n, $signed(got), $signed(e)); end
      n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d expected 66", n, lat); end
      if (n == 0) begin
        n_tests++; if (got !== 16'sd16383) begin n_fail++; $display("FAIL impulse_tap0_hand: got %0d expected 16383", $signed(got)); end
      end
      if (n == 1) begin
        n_tests++; if (got !== -16'sd2859) begin n_fail++; $display("FAIL impulse_tap1_hand: got %0d expected -2859", $signed(got)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got, e;
    logic        bs;
    int          lat;
    int          bad;
    run_sample(16'd777, 1'b0, 1'b1, -1, -1, got, bs, lat);
    model_push(16'sd777, 1'b0, e);
    n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL bp_latency: got %0d expected 66", lat); end
    n_tests++; if (got !== e) begin n_fail++; $display("FAIL bp_out: got %0d expected %0d", $signed(got), $signed(e)); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      in_valid  = (c % 2) == 1;
      in_sample = 16'd12345;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sample !== e || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b sample=%0d in_ready=%b expected 1/%0d/0",
                 c, out_valid, $signed(out_sample), in_ready, $signed(e));
      end
    end
    n_tests++; if (bad != 0) n_fail++;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    run_sample(16'd555, 1'b0, 1'b0, -1, -1, got, bs, lat);
    model_push(16'sd555, 1'b0, e);
    n_tests++; if (got !== e) begin n_fail++; $display("FAIL bp_no_dup: got %0d expected %0d", $signed(got), $signed(e)); end
  endtask

  task automatic test_bank_switch();
    logic [15:0] got, e;
    logic        bs;
    int          lat;
    run_sample(16'd3000, 1'b0, 1'b0, 20, -1, got, bs, lat);
    model_push(16'sd3000, 1'b0, e);
    n_tests++; if (got !== e) begin n_fail++; $display("FAIL bank_old_out: got %0d expected %0d", $signed(got), $signed(e)); end
    n_tests++; if (bs !== 1'b0) begin n_fail++; $display("FAIL bank_old_sel: got %b expected 0", bs); end
    n_tests++; if (rising_tone !== 1'b1) begin n_fail++; $display("FAIL bank_flip_reached: got %b expected 1", rising_tone); end
    run_sample(-16'sd2000, 1'b1, 1'b0, -1, -1, got, bs, lat);
    model_push(-16'sd2000, 1'b1, e);
    n_tests++; if (got !== e) begin n_fail++; $display("FAIL bank_new_out: got %0d expected %0d", $signed(got), $signed(e)); end
    n_tests++; if (bs !== 1'b1) begin n_fail++; $display("FAIL bank_new_sel: got %b expected 1", bs); end
  endtask

  task automatic test_reset_mid_mac();
    logic [15:0] got, e;
    logic        bs;
    int          lat;
    int          stale;
    run_sample(16'd1111, 1'b0, 1'b0, -1, 30, got, bs, lat);
    n_tests++; if (lat !== -2) begin n_fail++; $display("FAIL midmac_reached: got %0d expected -2", lat); end
    #1;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || coef_addr !== 6'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midmac_async: got valid=%b busy=%b addr=%0d in_ready=%b expected 0/0/0/0", out_valid, busy, coef_addr, in_ready);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_tests++; if (stale != 0) begin n_fail++; $display("FAIL midmac_stale: got %0d valid cycles expected 0", stale); end
    run_sample(16'd1000, 1'b0, 1'b0, -1, -1, got, bs, lat);
    model_push(16'sd1000, 1'b0, e);
    n_tests++; if (got !== e) begin n_fail++; $display("FAIL midmac_model: got %0d expected %0d", $signed(got), $signed(e)); end
    n_tests++; if (got !== 16'sd500) begin n_fail++; $display("FAIL midmac_hand: got %0d expected 500", $signed(got)); end
    n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL midmac_latency: got %0d expected 66", lat); end
  endtask

  task automatic test_full_scale();
    logic [15:0] got, e;
    logic        bs;
    int          lat;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 64; n++) begin
      run_sample(16'h8000, 1'b1, 1'b0, -1, -1, got, bs, lat);
      model_push(-16'sd32768, 1'b1, e);
      n_tests++; if (got !== e) begin n_fail++; $display("FAIL fullscale_out[%0d]: got %0d expected %0d", n, $signed(got), $signed(e)); end
      n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL fullscale_latency[%0d]: got %0d expected 66", n, lat); end
      if (n == 0) begin
        n_tests++; if (got !== -16'sd20000) begin n_fail++; $display("FAIL fullscale_hand0: got %0d expected -20000", $signed(got)); end
      end
`ifdef FIR_TAP_SEQ_SAT_EN
      if (n == 1) begin
        n_tests++; if (got !== 16'h8000) begin n_fail++; $display("FAIL fullscale_hand1: got %0d expected -32768", $signed(got)); end
      end
      if (n == 63) begin
        n_tests++; if (got !== 16'h8000) begin n_fail++; $display("FAIL fullscale_hand63: got %0d expected -32768", $signed(got)); end
      end
`else
      if (n == 1) begin
        n_tests++; if (got !== 16'sd25836) begin n_fail++; $display("FAIL fullscale_hand1: got %0d expected 25836", $signed(got)); end
      end
      if (n == 63) begin
        n_tests++; if (got !== -16'sd19840) begin n_fail++; $display("FAIL fullscale_hand63: got %0d expected -19840", $signed(got)); end
      end
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_latency();
    test_impulse();
    test_backpressure();
    test_bank_switch();
    test_reset_mid_mac();
    test_full_scale();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_seq.md
FIR_TAP_SEQ -- requirements
Module: fir_tap_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-002 Parameter NTAPS, default 64, SHALL set the tap count and coefficient address range.
REQ-003 Parameter DW, default 16, SHALL set the sample and coefficient width (two's complement).
REQ-004 Parameter ACCW, default 40, SHALL set the accumulator width.
REQ-005 Parameter QSHIFT, default 15, SHALL set the accumulator right-shift applied at output.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  input sample offered
- in_ready  out  1  block accepts a sample
- in_sample  in  DW  new signed sample
- rising_tone  in  1  coefficient bank request
- coef_addr  out  6  ROM tap address
- coef_bank  out  1  ROM bank select (drives the ROM RisingTone input)
- coef_data  in  DW  combinational ROM data for coef_addr/coef_bank
- out_valid  out  1  filtered sample valid
- out_ready  in  1  downstream accepts
- out_sample  out  DW  filtered signed sample
- busy  out  1  high in any state other than IDLE

Function
REQ-007 The FSM SHALL have states IDLE, MAC, ROUND and OUT.
REQ-008 IDLE SHALL drive in_ready=1; in_valid&in_ready SHALL write in_sample at wr_ptr, clear acc, set k=0, latch coef_bank<=rising_tone, and go to MAC.
REQ-009 In MAC, each cycle SHALL drive coef_addr=k and add coef_data * x[(wr_ptr-k) mod NTAPS] (full 2*DW signed product, sign-extended) into acc.
REQ-010 MAC SHALL last exactly NTAPS cycles (k=0..NTAPS-1); after k=NTAPS-1 the FSM SHALL go to ROUND.
REQ-011 ROUND SHALL compute acc >>> QSHIFT (arithmetic), register it to out_sample, increment wr_ptr mod NTAPS, and go to OUT.
REQ-012 OUT SHALL hold out_valid=1 and out_sample stable until out_ready=1, then return to IDLE in the next cycle.
REQ-013 Latency SHALL be: input handshake in cycle 0, out_valid first high in cycle NTAPS+2 (66 at default).
REQ-014 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored, with no sample lost or duplicated.
REQ-015 A change of rising_tone outside IDLE SHALL NOT affect coef_bank until the next accepted sample.
REQ-016 wr_ptr SHALL wrap from NTAPS-1 to 0; the read index SHALL wrap modulo NTAPS.
REQ-017 coef_addr SHALL be 0 in every state other than MAC.

Reset
REQ-018 With rst_n=0, asynchronously: state=IDLE, in_ready=0 for the duration of reset (1 from the first clock edge after release), out_valid=0, out_sample=0, coef_addr=0, coef_bank=0, busy=0, acc=0, k=0, wr_ptr=0.
REQ-019 Reset SHALL clear all NTAPS delay-line entries to 0; a reset mid-MAC SHALL abort the computation with no output produced.

Configuration
REQ-020 With FIR_TAP_SEQ_SAT_EN defined, ROUND SHALL saturate the shifted value to [-2^(DW-1), 2^(DW-1)-1].
REQ-021 Without FIR_TAP_SEQ_SAT_EN, ROUND SHALL truncate to the low DW bits (wrap).

Structure
REQ-022 Package fir_pkg SHALL hold NTAPS, DW, ACCW, QSHIFT defaults and the FSM state enum typedef.
REQ-023 The delay line SHALL be one sub-module, fir_delay_line: NTAPS x DW circular buffer, one write port and one combinational read port, with async clear.

Verification
REQ-024 Reset, then in_sample=0 -> out_sample=0, out_valid high exactly 66 cycles after the handshake.
REQ-025 Impulse 32767 then 63 zeros, bank 0 -> output n equals (32767*h0[n])>>>15, matching the bank-0 reference model for n=0..63.
REQ-026 out_ready held low 10 cycles in OUT -> out_valid and out_sample stay constant, in_ready=0, in_valid pulses ignored.
REQ-027 rising_tone toggled during MAC at k=20 -> current output uses the old bank; next sample uses the new bank.
REQ-028 rst_n asserted at MAC k=30, then sample 1000 -> no stale output, and result equals the single-sample model (delay line all 0).
REQ-029 Full-scale input -32768 for 64 samples -> with FIR_TAP_SEQ_SAT_EN defined, output clamped in range; without it, output equals the wrapped low 16 bits.
